// File: rtl/bpu_pkg.sv
// Shared branch-prediction types: branch type encodings, RAS and checkpoint sizing,
// and the checkpoint record saved per fetched control instruction.
package bpu_pkg;

  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_BRANCH = 2'b01,
    BR_RET    = 2'b10,
    BR_JUMP   = 2'b11
  } br_type_e;

  localparam int RAS_DEPTH  = 8;
  localparam int RAS_AW     = 3;
  localparam int DEPTH_W    = 4;
  localparam int CKPT_DEPTH = 4;
  localparam int CKPT_CW    = 3;

  typedef struct packed {
    logic [RAS_AW-1:0]  sp;
    logic [DEPTH_W-1:0] depth;
    logic [31:0]        top;
  } ckpt_t;

endpackage

// File: rtl/ras_stack_mem.sv
// 8x32 return-address storage: one synchronous write port, two async read ports.
// Zero latency on reads; no backpressure.
module ras_stack_mem
  import bpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [RAS_AW-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_dat,
  input  logic [RAS_AW-1:0] i_rd0_addr,
  output logic [31:0]       o_rd0_dat,
  input  logic [RAS_AW-1:0] i_rd1_addr,
  output logic [31:0]       o_rd1_dat
);

  logic [31:0] r_mem [RAS_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  assign o_rd0_dat = r_mem[i_rd0_addr];
  assign o_rd1_dat = r_mem[i_rd1_addr];

endmodule

// File: rtl/sync_fifo.sv
// Generic in-order FIFO with synchronous clear; head visible combinationally.
// Caller must not push when full or pop when empty (no internal backpressure).
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic [AW:0]  o_cnt
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !i_clr && i_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_cnt      = r_cnt;

endmodule

// File: rtl/ras_ctrl.sv
// Return address stack with per-event checkpoints for mispredict recovery.
// Return prediction is combinational; fetch stalls (fetch_ready_o=0) while 4 checkpoints are held.
module ras_ctrl
  import bpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   f_valid_i,
  input  logic [1:0]   f_type1_i,
  input  logic [1:0]   f_type2_i,
  input  logic [1:0]   f_link_i,
  input  logic [31:0]  f_pc1_i,
  input  logic [31:0]  f_pc2_i,
  output logic         fetch_ready_o,
  output logic         pred_valid_o,
  output logic         pred_slot_o,
  output logic [31:0]  pred_addr_o,
  input  logic         ex_resolve_i,
  input  logic         ex_mispredict_i,
  output logic [3:0]   depth_o,
  output logic [2:0]   ckpt_cnt_o
);

  logic [RAS_AW-1:0]  r_sp;
  logic [DEPTH_W-1:0] r_depth;

  logic               w_slot1_evt, w_slot2_evt, w_evt, w_slot, w_link;
  br_type_e           w_type;
  logic [31:0]        w_pc;
  logic               w_ready, w_restore, w_dequeue, w_accept, w_call, w_pop;
  logic [CKPT_CW-1:0] w_cnt;
  ckpt_t              w_head, w_ckpt_nxt;
  logic [31:0]        w_rd_top, w_rd_below;
  logic [RAS_AW-1:0]  w_sp_nxt;
  logic [DEPTH_W-1:0] w_depth_nxt;

  // Slot1 wins whenever it carries a control instruction.
  assign w_slot1_evt = f_valid_i[0] && (f_type1_i != BR_NONE);
  assign w_slot2_evt = f_valid_i[1] && (f_type2_i != BR_NONE);
  assign w_evt       = w_slot1_evt || w_slot2_evt;
  assign w_slot      = !w_slot1_evt;
  assign w_type      = w_slot1_evt ? br_type_e'(f_type1_i) : br_type_e'(f_type2_i);
  assign w_link      = w_slot1_evt ? f_link_i[0] : f_link_i[1];
  assign w_pc        = w_slot1_evt ? f_pc1_i : f_pc2_i;

  assign w_ready   = (w_cnt != CKPT_CW'(CKPT_DEPTH));
  assign w_restore = ex_resolve_i && ex_mispredict_i && (w_cnt != '0);
  assign w_dequeue = ex_resolve_i && !ex_mispredict_i && (w_cnt != '0);
  assign w_accept  = w_evt && w_ready && !w_restore;
  assign w_call    = w_accept && (w_type == BR_JUMP) && w_link;
  assign w_pop     = w_accept && (w_type == BR_RET) && (r_depth != '0);

  always_comb begin
    w_sp_nxt    = r_sp;
    w_depth_nxt = r_depth;
    w_ckpt_nxt  = '{sp: r_sp, depth: r_depth, top: w_rd_top};
    if (w_call) begin
      w_sp_nxt    = r_sp + 1'b1;
      w_depth_nxt = (r_depth == DEPTH_W'(RAS_DEPTH)) ? r_depth : r_depth + 1'b1;
      w_ckpt_nxt  = '{sp: w_sp_nxt, depth: w_depth_nxt, top: w_pc + 32'd8};
    end else if (w_pop) begin
      w_sp_nxt    = r_sp - 1'b1;
      w_depth_nxt = r_depth - 1'b1;
      w_ckpt_nxt  = '{sp: w_sp_nxt, depth: w_depth_nxt, top: w_rd_below};
    end
  end

  // Restore and call never coincide: a restore drops the fetch event.
  ras_stack_mem u_stack (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_call || w_restore),
    .i_wr_addr  (w_restore ? w_head.sp : r_sp + 1'b1),
    .i_wr_dat   (w_restore ? w_head.top : w_pc + 32'd8),
    .i_rd0_addr (r_sp),
    .o_rd0_dat  (w_rd_top),
    .i_rd1_addr (r_sp - 1'b1),
    .o_rd1_dat  (w_rd_below)
  );

  sync_fifo #(.W($bits(ckpt_t)), .DEPTH(CKPT_DEPTH)) u_ckpt_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_restore),
    .i_push     (w_accept),
    .i_push_dat (w_ckpt_nxt),
    .i_pop      (w_dequeue),
    .o_head_dat (w_head),
    .o_cnt      (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sp    <= '0;
      r_depth <= '0;
    end else if (w_restore) begin
      r_sp    <= w_head.sp;
      r_depth <= w_head.depth;
    end else begin
      r_sp    <= w_sp_nxt;
      r_depth <= w_depth_nxt;
    end
  end

  assign fetch_ready_o = rst && w_ready;
  assign pred_valid_o  = rst && w_pop;
  assign pred_slot_o   = rst && w_pop && w_slot;
  assign pred_addr_o   = (rst && w_pop) ? w_rd_top : 32'd0;
  assign depth_o       = rst ? r_depth : 4'd0;
  assign ckpt_cnt_o    = rst ? w_cnt : 3'd0;

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed scenarios plus random traffic, all cycles scored
// against a stack/queue reference model.
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  f_valid_i, f_type1_i, f_type2_i, f_link_i;
  logic [31:0] f_pc1_i, f_pc2_i;
  logic        fetch_ready_o, pred_valid_o, pred_slot_o;
  logic [31:0] pred_addr_o;
  logic        ex_resolve_i, ex_mispredict_i;
  logic [3:0]  depth_o;
  logic [2:0]  ckpt_cnt_o;

  always #5 clk = ~clk;

  ras_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .f_valid_i       (f_valid_i),
    .f_type1_i       (f_type1_i),
    .f_type2_i       (f_type2_i),
    .f_link_i        (f_link_i),
    .f_pc1_i         (f_pc1_i),
    .f_pc2_i         (f_pc2_i),
    .fetch_ready_o   (fetch_ready_o),
    .pred_valid_o    (pred_valid_o),
    .pred_slot_o     (pred_slot_o),
    .pred_addr_o     (pred_addr_o),
    .ex_resolve_i    (ex_resolve_i),
    .ex_mispredict_i (ex_mispredict_i),
    .depth_o         (depth_o),
    .ckpt_cnt_o      (ckpt_cnt_o)
  );

  typedef struct {
    int          sp;
    int          depth;
    logic [31:0] top;
  } ck_t;

  logic [31:0] m_stack [8];
  int          m_sp, m_depth;
  ck_t         m_q [$];

  int          n_cmp = 0;
  int          n_err = 0;

  logic        e_pred, e_slot, e_ready, e_link, e_acc, e_restore, e_deq;
  logic [31:0] e_addr, e_pc;
  int          e_type;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit s1, s2;
    s1        = f_valid_i[0] && (f_type1_i != 2'b00);
    s2        = f_valid_i[1] && (f_type2_i != 2'b00);
    e_slot    = !s1;
    e_type    = s1 ? int'(f_type1_i) : (s2 ? int'(f_type2_i) : 0);
    e_link    = s1 ? f_link_i[0] : f_link_i[1];
    e_pc      = s1 ? f_pc1_i : f_pc2_i;
    e_restore = ex_resolve_i && ex_mispredict_i && (m_q.size() > 0);
    e_deq     = ex_resolve_i && !ex_mispredict_i && (m_q.size() > 0);
    e_ready   = (m_q.size() < 4);
    e_acc     = (e_type != 0) && e_ready && !e_restore;
    e_pred    = e_acc && (e_type == 2) && (m_depth > 0);
    e_addr    = e_pred ? m_stack[m_sp] : 32'd0;
  endtask

  task automatic model_edge();
    ck_t c;
    if (!rst) begin
      foreach (m_stack[i]) m_stack[i] = 32'd0;
      m_sp    = 0;
      m_depth = 0;
      m_q.delete();
    end else if (e_restore) begin
      c       = m_q[0];
      m_sp    = c.sp;
      m_depth = c.depth;
      m_stack[m_sp] = c.top;
      m_q.delete();
    end else begin
      if (e_deq) void'(m_q.pop_front());
      if (e_acc) begin
        if (e_type == 3 && e_link) begin
          m_sp = (m_sp + 1) % 8;
          m_stack[m_sp] = e_pc + 32'd8;
          if (m_depth < 8) m_depth++;
        end else if (e_type == 2 && m_depth > 0) begin
          m_sp = (m_sp + 7) % 8;
          m_depth--;
        end
        c.sp = m_sp; c.depth = m_depth; c.top = m_stack[m_sp];
        m_q.push_back(c);
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs are scored 1ns later.
  task automatic cycle();
    #1;
    model_eval();
    chk("pred_valid",  pred_valid_o,  rst ? e_pred : 1'b0);
    chk("pred_slot",   pred_slot_o,   (rst && e_pred) ? e_slot : 1'b0);
    chk("pred_addr",   pred_addr_o,   rst ? e_addr : 32'd0);
    chk("fetch_ready", fetch_ready_o, rst ? e_ready : 1'b0);
    chk("depth",       depth_o,       rst ? m_depth : 0);
    chk("ckpt_cnt",    ckpt_cnt_o,    rst ? m_q.size() : 0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    f_valid_i = 2'b00; f_type1_i = 2'b00; f_type2_i = 2'b00; f_link_i = 2'b00;
    f_pc1_i = 32'd0; f_pc2_i = 32'd0; ex_resolve_i = 1'b0; ex_mispredict_i = 1'b0;
  endtask

  task automatic ev1(input logic [1:0] t, input logic l, input logic [31:0] pc);
    f_valid_i = 2'b01; f_type1_i = t; f_type2_i = 2'b00;
    f_link_i = {1'b0, l}; f_pc1_i = pc;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_ready", fetch_ready_o, 1'b1);
    chk("rst_depth", depth_o, 4'd0);
    chk("rst_cnt",   ckpt_cnt_o, 3'd0);

    // call at slot1, return predicted from slot2
    ev1(2'b11, 1'b1, 32'h1000); cycle();
    idle(); f_valid_i = 2'b11; f_type2_i = 2'b10;
    #1;
    chk("r27_vld",  pred_valid_o, 1'b1);
    chk("r27_slot", pred_slot_o, 1'b1);
    chk("r27_addr", pred_addr_o, 32'h1008);
    chk("r27_dpre", depth_o, 4'd1);
    cycle(); #1;
    chk("r27_dpost", depth_o, 4'd0);

    // return on an empty stack still checkpoints
    do_reset();
    ev1(2'b10, 1'b0, 32'h0); #1;
    chk("r28_vld", pred_valid_o, 1'b0);
    cycle(); #1;
    chk("r28_cnt",   ckpt_cnt_o, 3'd1);
    chk("r28_depth", depth_o, 4'd0);

    // overflow: nine calls, eight good returns, then empty
    do_reset();
    ex_resolve_i = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      ev1(2'b11, 1'b1, 32'(i * 256)); cycle();
    end
    #1; chk("r29_depth", depth_o, 4'd8);
    for (int k = 0; k < 9; k++) begin
      ev1(2'b10, 1'b0, 32'h0); #1;
      chk("r29_vld",  pred_valid_o, (k < 8) ? 1'b1 : 1'b0);
      chk("r29_addr", pred_addr_o, (k < 8) ? 32'((9 - k) * 256 + 8) : 32'd0);
      cycle();
    end

    // checkpoint FIFO full stalls fetch
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ev1(2'b01, 1'b0, 32'(i * 4)); cycle();
    end
    #1;
    chk("r30_ready", fetch_ready_o, 1'b0);
    chk("r30_full",  ckpt_cnt_o, 3'd4);
    cycle(); #1;
    chk("r30_rej", ckpt_cnt_o, 3'd4);
    idle(); ex_resolve_i = 1'b1; cycle();
    ev1(2'b01, 1'b0, 32'h40); cycle(); #1;
    chk("r30_same", ckpt_cnt_o, 3'd3);
    idle();

    // wrong-path call repaired by mispredict on the older branch
    do_reset();
    ev1(2'b11, 1'b1, 32'h2000); cycle();
    ev1(2'b01, 1'b0, 32'h2004); cycle();
    ev1(2'b11, 1'b1, 32'h3000); cycle();
    idle(); ex_resolve_i = 1'b1; cycle();
    ex_mispredict_i = 1'b1; ev1(2'b10, 1'b0, 32'h0); #1;
    chk("r31_drop", pred_valid_o, 1'b0);
    cycle(); idle(); #1;
    chk("r31_depth", depth_o, 4'd1);
    chk("r31_cnt",   ckpt_cnt_o, 3'd0);
    ev1(2'b10, 1'b0, 32'h0); #1;
    chk("r31_top", pred_addr_o, 32'h2008);
    cycle(); idle();

    // reset in the middle of activity
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ex_resolve_i = (i < 3);
      ev1(2'b11, 1'b1, 32'(32'h500 + i * 16)); cycle();
    end
    idle(); #1;
    chk("r32_depth5", depth_o, 4'd5);
    chk("r32_cnt3",   ckpt_cnt_o, 3'd3);
    rst = 1'b0; ev1(2'b10, 1'b0, 32'h0); ex_resolve_i = 1'b1; #1;
    chk("r32_vld_in_rst", pred_valid_o, 1'b0);
    chk("r32_rdy_in_rst", fetch_ready_o, 1'b0);
    cycle(); #1;
    chk("r32_depth0", depth_o, 4'd0);
    chk("r32_cnt0",   ckpt_cnt_o, 3'd0);
    rst = 1'b1; ex_resolve_i = 1'b0; #1;
    chk("r32_ready", fetch_ready_o, 1'b1);
    chk("r32_noret", pred_valid_o, 1'b0);
    cycle(); idle();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      rst             = ($urandom_range(63) != 0);
      f_valid_i       = 2'($urandom);
      f_type1_i       = 2'($urandom);
      f_type2_i       = 2'($urandom);
      f_link_i        = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b11;
      f_pc1_i         = $urandom & 32'hffff_fffc;
      f_pc2_i         = $urandom & 32'hffff_fffc;
      ex_resolve_i    = ($urandom_range(2) == 0);
      ex_mispredict_i = ($urandom_range(3) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
